// File: rtl/spi_burst_rx.sv
// Burst-clock serial receiver: oversamples sclk_in/sdata_in, assembles MSB-first words
// and buffers them in a show-ahead FIFO; a frame-gap timeout discards partial words.
module spi_burst_rx #(
    parameter int WORD_BITS  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 64
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 sclk_in,
    input  logic                 sdata_in,
    input  logic                 rd_en,
    output logic [WORD_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_BITS);
    localparam int TW = $clog2(GAP_CYCLES);
    localparam logic [CW-1:0] BIT_LAST = CW'(WORD_BITS - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_nxt;
    logic   [CW-1:0]       bit_cnt, bit_cnt_nxt;
    logic   [TW-1:0]       gap_tmr, gap_tmr_nxt;
    logic                  cap, push_nxt, ferr_nxt;

    logic                  sclk_p0, sclk_p1, sclk_p2;
    logic                  sdata_p0, sdata_p1;
    logic                  rise;
    logic [WORD_BITS-2:0]  shreg;
    logic [WORD_BITS-1:0]  shift_word;

    logic [WORD_BITS-1:0]  word_p3;
    logic                  vld_p3;

    logic [WORD_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  pop, wr_ok;

    // Stage p0/p1: two-flop synchronizers; p2: previous sclk for rise detection
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sclk_p0  <= 1'b0;
            sclk_p1  <= 1'b0;
            sclk_p2  <= 1'b0;
            sdata_p0 <= 1'b0;
            sdata_p1 <= 1'b0;
        end else begin
            sclk_p0  <= sclk_in;
            sclk_p1  <= sclk_p0;
            sclk_p2  <= sclk_p1;
            sdata_p0 <= sdata_in;
            sdata_p1 <= sdata_p0;
        end
    end

    assign rise       = sclk_p1 & ~sclk_p2;
    assign shift_word = {shreg, sdata_p1};

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            gap_tmr   <= '0;
            frame_err <= 1'b0;
            vld_p3    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_tmr   <= gap_tmr_nxt;
            frame_err <= ferr_nxt;
            vld_p3    <= push_nxt;
        end
    end

    // A rise always takes priority over a simultaneous timeout
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        gap_tmr_nxt = gap_tmr;
        cap         = 1'b0;
        push_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                gap_tmr_nxt = '0;
                if (rise) begin
                    cap         = 1'b1;
                    bit_cnt_nxt = CW'(1);
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    cap         = 1'b1;
                    gap_tmr_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        push_nxt    = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else if (gap_tmr == GAP_LAST) begin
                    ferr_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                    gap_tmr_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_tmr_nxt = gap_tmr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // Stage p3: completed word registered one cycle before it enters the FIFO
    always_ff @(posedge clk_in) begin
        if (cap)
            shreg <= shift_word[WORD_BITS-2:0];
        if (push_nxt)
            word_p3 <= shift_word;
        if (wr_ok)
            mem[wr_ptr[AW-1:0]] <= word_p3;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = rd_en & ~empty;
    assign wr_ok = vld_p3 & (~full | pop);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (vld_p3 && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_burst_rx.sv
// Directed bench for spi_burst_rx: bursts at 8 clk_in per sclk period, hand-computed words.
module tb_spi_burst_rx;

    localparam int WB  = 16;
    localparam int FD  = 4;
    localparam int GAP = 64;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          sclk_in = 1'b0;
    logic          sdata_in = 1'b0;
    logic          rd_en = 1'b0;
    logic [WB-1:0] dout;
    logic          empty, full, busy, frame_err, overflow;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;

    spi_burst_rx #(.WORD_BITS(WB), .FIFO_DEPTH(FD), .GAP_CYCLES(GAP)) dut (
        .clk_in(clk_in), .rst(rst), .sclk_in(sclk_in), .sdata_in(sdata_in),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .busy(busy),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

    task automatic send_bit(input logic b);
        sdata_in = b;
        @(negedge clk_in);
        sclk_in = 1'b1;
        repeat (4) @(negedge clk_in);
        sclk_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    // Raises sclk and returns 1 time unit after the edge that captures the bit
    task automatic rise_last(input logic b);
        sdata_in = b;
        @(negedge clk_in);
        sclk_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    task automatic finish_low();
        @(negedge clk_in);
        sclk_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic send_word(input logic [WB-1:0] w);
        for (int i = WB - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_head(input logic [WB-1:0] w);
        for (int i = WB - 1; i >= 1; i--) send_bit(w[i]);
    endtask

    task automatic pop_word();
        @(negedge clk_in);
        rd_en = 1'b1;
        @(negedge clk_in);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        send_head(16'hA55A);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b expected 1", busy); end
        rise_last(1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_rise3: got %b expected 1", empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b expected 0", busy); end
        @(posedge clk_in); #1;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_rise4: got %b expected 0", empty); end
        checks++; if (dout !== 16'hA55A) begin errors++; $display("FAIL single_dout: got %h expected a55a", dout); end
        finish_low();
        pop_word();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_pop: got %b expected 1", empty); end
    endtask

    task automatic test_gapped();
        logic [WB-1:0] w;
        int f0;
        w = 16'h1234;
        f0 = ferr_cnt;
        for (int i = WB - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == 4) repeat (20) @(negedge clk_in);
        end
        checks++; if (dout !== 16'h1234) begin errors++; $display("FAIL gapped_dout: got %h expected 1234", dout); end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL gapped_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
        pop_word();
    endtask

    task automatic test_timeout();
        int hi, first;
        logic busy_b;
        hi = 0; first = -1; busy_b = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        rise_last(1'b1);
        for (int k = 1; k <= GAP + 2; k++) begin
            @(posedge clk_in); #1;
            if (frame_err === 1'b1) begin
                hi++;
                if (first < 0) first = k;
            end
            if (k == GAP - 1) busy_b = busy;
        end
        checks++; if (hi !== 1) begin errors++; $display("FAIL timeout_pulse_len: got %0d expected 1", hi); end
        checks++; if (first !== GAP) begin errors++; $display("FAIL timeout_pulse_pos: got %0d expected %0d", first, GAP); end
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL timeout_busy_before: got %b expected 1", busy_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after: got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL timeout_empty: got %b expected 1", empty); end
        finish_low();
        send_word(16'hBEEF);
        checks++; if (dout !== 16'hBEEF || empty !== 1'b0) begin errors++; $display("FAIL timeout_next_word: got %h/%b expected beef/0", dout, empty); end
        pop_word();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL timeout_next_pop: got %b expected 1", empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 1; v <= 5; v++) send_word(WB'(v));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        for (int v = 1; v <= 4; v++) begin
            checks++; if (dout !== WB'(v)) begin errors++; $display("FAIL ovf_read%0d: got %h expected %h", v, dout, WB'(v)); end
            pop_word();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int v = 1; v <= 4; v++) send_word(WB'(v));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fb_full_before: got %b expected 1", full); end
        send_head(16'h0005);
        rise_last(1'b1);
        rd_en = 1'b1;
        @(posedge clk_in); #1;
        rd_en = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fb_full_after: got %b expected 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fb_overflow: got %b expected 0", overflow); end
        finish_low();
        for (int v = 2; v <= 5; v++) begin
            checks++; if (dout !== WB'(v)) begin errors++; $display("FAIL fb_read%0d: got %h expected %h", v, dout, WB'(v)); end
            pop_word();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fb_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_midword();
        int f0;
        do_reset();
        send_word(16'h1111);
        send_word(16'h2222);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        checks++; if (busy !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL rmw_pre: got busy %b empty %b expected 1/0", busy, empty); end
        @(negedge clk_in);
        rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmw_flags: got e%b f%b b%b expected e1 f0 b0", empty, full, busy); end
        checks++; if (dout !== 16'h0000 || overflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rmw_outs: got %h o%b fe%b expected 0000 o0 fe0", dout, overflow, frame_err); end
        @(negedge clk_in);
        rst = 1'b0;
        f0 = ferr_cnt;
        repeat (GAP + 5) @(negedge clk_in);
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL rmw_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
        send_word(16'h00FF);
        checks++; if (dout !== 16'h00FF) begin errors++; $display("FAIL rmw_word: got %h expected 00ff", dout); end
        pop_word();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmw_alone: got %b expected 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gapped();
        test_timeout();
        test_overflow();
        test_full_boundary();
        test_reset_midword();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_burst_rx.md
# spi_burst_rx

Serial burst receiver and word buffer, the receiving end of the gated burst-clock serial link. Oversamples an incoming burst clock (`sclk_in`) and data line (`sdata_in`) on the local `clk_in`, shifts bits MSB-first into WORD_BITS-bit words, and pushes each completed word into a small show-ahead FIFO. A frame-gap timeout discards partial words and flags the error. Sits at the link input, ahead of the word consumer logic.

## Interface
- WORD_BITS, 16, bits per word; range 2..32
- FIFO_DEPTH, 4, word FIFO entries; power of 2, range 2..16
- GAP_CYCLES, 64, idle `clk_in` cycles after the last detected `sclk_in` rise that abort a partial word; range 4..1023

- clk_in  input  1  single system clock; all logic is clocked on its rising edge
- rst  input  1  asynchronous, active-high reset
- sclk_in  input  1  asynchronous serial burst clock; data is valid at its rising edge
- sdata_in  input  1  asynchronous serial data, MSB first
- rd_en  input  1  pops the head word when `empty`=0; ignored when `empty`=1
- dout  output  WORD_BITS  head word of the FIFO, valid whenever `empty`=0
- empty  output  1  FIFO holds no words
- full  output  1  FIFO holds FIFO_DEPTH words
- busy  output  1  a partial word is being shifted (state SHIFT)
- frame_err  output  1  one-cycle pulse when a partial word is discarded on timeout
- overflow  output  1  sticky; set when a completed word is dropped because the FIFO is full

## Operation
- Input conditioning: `sclk_in` and `sdata_in` each pass through a 2-flop synchronizer; a third flop on synchronized `sclk_in` provides rise detection (sync=1, prev=0). Data is sampled from the synchronized `sdata_in` in the same cycle the rise is detected.
- Shift register: on each detected rise, shreg <= {shreg[WORD_BITS-2:0], bit}; bit counter increments by 1.
- FSM states:
  - IDLE: bit count 0, gap timer 0. Rise -> capture bit, go to SHIFT.
  - SHIFT: each rise captures a bit and clears the gap timer; otherwise the timer increments. When the WORD_BITS-th bit is captured, the word is pushed, bit count returns to 0, and the FSM returns to IDLE. When the timer reaches GAP_CYCLES-1 with no rise: discard the partial word, pulse `frame_err`, go to IDLE.
- A rise and a timeout in the same cycle: the rise wins; no error.
- Gaps inside a burst shorter than GAP_CYCLES (e.g. one missing pulse) are tolerated; shifting resumes on the next rise.
- FIFO: FIFO_DEPTH entries; read/write pointers are log2(FIFO_DEPTH)+1 bits wide with wrap bit; `empty` = pointers equal; `full` = indices equal and wrap bits differ.
- Push when full without a same-cycle pop: the word is dropped and `overflow` is set (held until `rst`). Push and pop in the same cycle when full: both succeed and `full` stays 1.
- Pop with `rd_en`=1 and `empty`=0 advances the read pointer; `dout` shows the next word on the following cycle.
- `rst` mid-word or mid-FIFO: all state is cleared immediately; partial word and buffered words are lost; no `frame_err` is generated.

## Timing
- Reset values: `dout`=0, `empty`=1, `full`=0, `busy`=0, `frame_err`=0, `overflow`=0; synchronizer flops 0.
- `sclk_in` high and low must each be >= 2 `clk_in` cycles; `sdata_in` must be stable from 1 cycle before to 2 cycles after each `sclk_in` rise.
- Rise detected 3 `clk_in` edges after the `sclk_in` transition (2 sync + 1 detect).
- Last bit detected at cycle N -> word written at edge N+1 -> `empty`=0 and `dout` valid from N+1.
- `busy` rises the cycle after the first bit is captured and falls with the push or the timeout.
- `frame_err` is high for exactly the one cycle after the timeout edge.
- Pop at cycle P -> `empty`/`full`/`dout` updated at P+1.

## Test plan
- Single word: 16 bursts at 8 `clk_in`/period sending 0xA55A -> `empty` falls 4 cycles after the last rise, `dout`=0xA55A; `rd_en` pulse -> `empty`=1.
- Gapped burst: 0x1234 sent with one 20-cycle gap after bit 12 -> `dout`=0x1234, `frame_err` never asserted.
- Timeout: 9 bits then silence -> `frame_err` one-cycle pulse GAP_CYCLES cycles after the last rise, `busy`=0, `empty` stays 1; next 16-bit word 0xBEEF received correctly.
- Overflow: 5 words (0x0001..0x0005) with no reads, FIFO_DEPTH=4 -> `full`=1, `overflow`=1, reads return 0x0001..0x0004, then `empty`=1.
- Full boundary: FIFO full and a 5th word completes in the same cycle `rd_en`=1 -> no overflow, `full` stays 1, reads return words 2..5.
- Reset mid-word: `rst` pulse after 7 bits with 2 words buffered -> all outputs at reset values; a following word 0x00FF is received alone.
